// File: rtl/volume_step_ctrl.sv
// Volume stepper: debounced vol-/vol+ levels -> saturating level with press step and auto-repeat,
// pushed to the codec write path via req/ack. Define VOL_MUTE_EN to add the two-button mute toggle.
module volume_step_ctrl #(
  parameter int VOL_W        = 5,
  parameter int VOL_MAX      = 31,
  parameter int VOL_INIT     = 16,
  parameter int HOLD_TICKS   = 12500000,
  parameter int REPEAT_TICKS = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_minus_n,
  input  logic             btn_plus_n,
  input  logic             enable,
  output logic [VOL_W-1:0] vol_o,
  output logic             mute_o,
  output logic             wr_req_o,
  output logic [VOL_W:0]   wr_data_o,
  input  logic             wr_ack_i
);
  localparam int TICK_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W    = $clog2(TICK_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [VOL_W-1:0] VOL_TOP     = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VOL_RST     = VOL_W'(VOL_INIT);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD, S_REPEAT} state_t;

  // [1:0] synchroniser, [2] previous synchronised level for edge detect
  logic [2:0]       minus_sync_reg, plus_sync_reg;
  state_t           state_reg;
  logic             dir_up_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [VOL_W-1:0] vol_reg, vol_next;
  logic             mute_reg, mute_next;
  logic             dirty_reg, wr_req_reg;
  logic [VOL_W:0]   wr_data_reg;
  logic             minus_lvl, plus_lvl, press_minus, press_plus, held;
  logic             step_fire, mute_toggle, changed;
`ifdef VOL_MUTE_EN
  logic             wait_rel_reg;
`endif

  assign minus_lvl   = minus_sync_reg[1];
  assign plus_lvl    = plus_sync_reg[1];
  assign press_minus = minus_sync_reg[2] & ~minus_sync_reg[1];
  assign press_plus  = plus_sync_reg[2] & ~plus_sync_reg[1];
  assign held        = dir_up_reg ? ~plus_lvl : ~minus_lvl;

`ifdef VOL_MUTE_EN
  assign mute_toggle = enable && (state_reg == S_IDLE) && !wait_rel_reg && press_minus && press_plus;
`else
  assign mute_toggle = 1'b0;
`endif

  always_comb begin
    step_fire = 1'b0;
    case (state_reg)
      S_STEP:           step_fire = enable;
      S_HOLD, S_REPEAT: step_fire = enable && held && (cnt_reg == '0);
      default:          step_fire = 1'b0;
    endcase
  end

  always_comb begin
    vol_next = vol_reg;
    if (step_fire) begin
      if (dir_up_reg) vol_next = (vol_reg >= VOL_TOP) ? vol_reg : vol_reg + VOL_W'(1);
      else            vol_next = (vol_reg == '0) ? vol_reg : vol_reg - VOL_W'(1);
    end
`ifdef VOL_MUTE_EN
    mute_next = step_fire ? 1'b0 : (mute_toggle ? ~mute_reg : mute_reg);
`else
    mute_next = 1'b0;
`endif
    changed = (vol_next != vol_reg) || (mute_next != mute_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      minus_sync_reg <= '1;
      plus_sync_reg  <= '1;
      state_reg      <= S_IDLE;
      dir_up_reg     <= 1'b0;
      cnt_reg        <= '0;
      vol_reg        <= VOL_RST;
      mute_reg       <= 1'b0;
`ifdef VOL_MUTE_EN
      wait_rel_reg   <= 1'b0;
`endif
    end else begin
      minus_sync_reg <= {minus_sync_reg[1:0], btn_minus_n};
      plus_sync_reg  <= {plus_sync_reg[1:0], btn_plus_n};
      vol_reg        <= vol_next;
      mute_reg       <= mute_next;
      if (!enable) begin
        state_reg <= S_IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
`ifdef VOL_MUTE_EN
            // After a mute toggle, nothing is accepted until both buttons are up
            if (wait_rel_reg) begin
              if (minus_lvl && plus_lvl) wait_rel_reg <= 1'b0;
            end else if (press_minus && press_plus) begin
              wait_rel_reg <= 1'b1;
            end else
`endif
            if (press_plus && !press_minus) begin
              dir_up_reg <= 1'b1;
              state_reg  <= S_STEP;
            end else if (press_minus && !press_plus) begin
              dir_up_reg <= 1'b0;
              state_reg  <= S_STEP;
            end
          end
          S_STEP: begin
            cnt_reg   <= HOLD_LOAD;
            state_reg <= S_HOLD;
          end
          S_HOLD, S_REPEAT: begin
            if (!held) begin
              state_reg <= S_IDLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == '0) begin
              cnt_reg   <= REPEAT_LOAD;
              state_reg <= S_REPEAT;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // Changes arriving while a request is outstanding are folded into one follow-up write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_req_reg  <= 1'b1;
      wr_data_reg <= {1'b0, VOL_RST};
      dirty_reg   <= 1'b0;
    end else if (wr_req_reg) begin
      dirty_reg <= dirty_reg | changed;
      if (wr_ack_i) wr_req_reg <= 1'b0;
    end else if (dirty_reg) begin
      wr_req_reg  <= 1'b1;
      wr_data_reg <= {mute_reg, vol_reg};
      dirty_reg   <= changed;
    end else begin
      dirty_reg <= changed;
    end
  end

  assign vol_o     = vol_reg;
  assign mute_o    = mute_reg;
  assign wr_req_o  = wr_req_reg;
  assign wr_data_o = wr_data_reg;
endmodule

// File: tb/tb_volume_step_ctrl.sv
// Directed bench for volume_step_ctrl with HOLD_TICKS=20, REPEAT_TICKS=5.
module tb_volume_step_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_minus_n = 1'b1;
  logic       btn_plus_n = 1'b1;
  logic       enable = 1'b1;
  logic [4:0] vol_o;
  logic       mute_o;
  logic       wr_req_o;
  logic [5:0] wr_data_o;
  logic       wr_ack_i = 1'b0;
  int         total = 0;
  int         bad = 0;

  volume_step_ctrl #(
    .VOL_W(5), .VOL_MAX(31), .VOL_INIT(16), .HOLD_TICKS(20), .REPEAT_TICKS(5)
  ) dut (
    .clk(clk), .reset(reset), .btn_minus_n(btn_minus_n), .btn_plus_n(btn_plus_n),
    .enable(enable), .vol_o(vol_o), .mute_o(mute_o), .wr_req_o(wr_req_o),
    .wr_data_o(wr_data_o), .wr_ack_i(wr_ack_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits (bounded) for a request, acknowledges it for one cycle, returns its data
  task automatic ack_once(output logic [5:0] data, output bit seen);
    seen = 1'b0;
    data = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (wr_req_o === 1'b1) begin
        seen = 1'b1;
        data = wr_data_o;
      end else tick();
    end
    if (seen) begin
      wr_ack_i = 1'b1;
      tick();
      wr_ack_i = 1'b0;
      $display("write: data=%h", data);
    end
  endtask

  task automatic init_dut();
    btn_minus_n = 1'b1; btn_plus_n = 1'b1; enable = 1'b1; wr_ack_i = 1'b0;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    ticks(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(2);
    total++; if (vol_o !== 5'd16) begin bad++; $display("FAIL reset_vol: got %0d need 16", vol_o); end
    total++; if (mute_o !== 1'b0) begin bad++; $display("FAIL reset_mute: got %b need 0", mute_o); end
    total++; if (wr_req_o !== 1'b1) begin bad++; $display("FAIL reset_req: got %b need 1", wr_req_o); end
    total++; if (wr_data_o !== 6'h10) begin bad++; $display("FAIL reset_data: got %h need 10", wr_data_o); end
    reset = 1'b0;
    ticks(3);
    total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h10) begin bad++; $display("FAIL init_req_held: got req=%b data=%h need 1/10", wr_req_o, wr_data_o); end
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL init_req_drop: got %b need 0", wr_req_o); end
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    ticks(3);
    total++; if (wr_req_o !== 1'b0 || vol_o !== 5'd16) begin bad++; $display("FAIL stray_ack: got req=%b vol=%0d need 0/16", wr_req_o, vol_o); end
  endtask

  task automatic test_tap();
    logic [5:0] d;
    bit         seen;
    int         changes;
    logic [4:0] prev;
    init_dut();
    btn_plus_n = 1'b0;
    ticks(3);
    btn_plus_n = 1'b1;
    total++; if (vol_o !== 5'd16) begin bad++; $display("FAIL tap_before_step: got %0d need 16", vol_o); end
    tick();
    total++; if (vol_o !== 5'd17) begin bad++; $display("FAIL tap_step_latency: got %0d need 17", vol_o); end
    tick();
    total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h11) begin bad++; $display("FAIL tap_req: got req=%b data=%h need 1/11", wr_req_o, wr_data_o); end
    changes = 0;
    prev = vol_o;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (vol_o !== prev) changes++;
      prev = vol_o;
    end
    total++; if (changes !== 0 || vol_o !== 5'd17) begin bad++; $display("FAIL tap_single_step: got changes=%0d vol=%0d need 0/17", changes, vol_o); end
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h11) begin bad++; $display("FAIL tap_ack: got seen=%b data=%h need 1/11", seen, d); end
    ticks(10);
    total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL tap_one_request: got req=%b need 0", wr_req_o); end
  endtask

  task automatic test_hold_repeat();
    logic [5:0] d;
    bit         seen;
    int         n;
    logic [4:0] exp_vol;
    init_dut();
    btn_minus_n = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 40) btn_minus_n = 1'b1;
      n = int'(k >= 4) + int'(k >= 24) + int'(k >= 29) + int'(k >= 34) + int'(k >= 39);
      exp_vol = 5'(16 - n);
      total++; if (vol_o !== exp_vol) begin bad++; $display("FAIL hold_vol_cycle%0d: got %0d need %0d", k, vol_o, exp_vol); end
      if (k == 5) begin
        total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h0F) begin bad++; $display("FAIL hold_first_req: got req=%b data=%h need 1/0f", wr_req_o, wr_data_o); end
      end
    end
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h0F) begin bad++; $display("FAIL hold_ack1: got seen=%b data=%h need 1/0f", seen, d); end
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h0B) begin bad++; $display("FAIL hold_coalesced: got seen=%b data=%h need 1/0b", seen, d); end
    ticks(10);
    total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL hold_no_extra_req: got req=%b need 0", wr_req_o); end
  endtask

  task automatic test_saturate();
    logic [5:0] d;
    bit         seen;
    logic [4:0] exp_vol;
    init_dut();
    btn_plus_n = 1'b0;
    ticks(85);
    btn_plus_n = 1'b1;
    ticks(6);
    total++; if (vol_o !== 5'd30) begin bad++; $display("FAIL sat_reach30: got %0d need 30", vol_o); end
    btn_plus_n = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 35) btn_plus_n = 1'b1;
      exp_vol = (k >= 4) ? 5'd31 : 5'd30;
      total++; if (vol_o !== exp_vol) begin bad++; $display("FAIL sat_vol_cycle%0d: got %0d need %0d", k, vol_o, exp_vol); end
    end
    ticks(10);
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h11) begin bad++; $display("FAIL sat_stale_req: got seen=%b data=%h need 1/11", seen, d); end
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h1F) begin bad++; $display("FAIL sat_followup: got seen=%b data=%h need 1/1f", seen, d); end
    ticks(10);
    total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL sat_single_followup: got req=%b need 0", wr_req_o); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] d;
    bit         seen;
    init_dut();
    btn_plus_n = 1'b0;
    ticks(3);
    btn_plus_n = 1'b1;
    ticks(7);
    btn_plus_n = 1'b0;
    ticks(3);
    btn_plus_n = 1'b1;
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    total++; if (vol_o !== 5'd18 || wr_req_o !== 1'b0) begin bad++; $display("FAIL b2b_drop: got vol=%0d req=%b need 18/0", vol_o, wr_req_o); end
    tick();
    total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h12) begin bad++; $display("FAIL b2b_reraise: got req=%b data=%h need 1/12", wr_req_o, wr_data_o); end
    ack_once(d, seen);
    ticks(5);
    total++; if (wr_req_o !== 1'b0) begin bad++; $display("FAIL b2b_idle: got req=%b need 0", wr_req_o); end
  endtask

  task automatic test_enable();
    logic [5:0] d;
    bit         seen;
    logic [4:0] exp_vol;
    init_dut();
    btn_plus_n = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 10) enable = 1'b0;
      if (k == 40) enable = 1'b1;
      exp_vol = (k >= 4) ? 5'd17 : 5'd16;
      total++; if (vol_o !== exp_vol) begin bad++; $display("FAIL en_vol_cycle%0d: got %0d need %0d", k, vol_o, exp_vol); end
    end
    btn_plus_n = 1'b1;
    ticks(5);
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h11) begin bad++; $display("FAIL en_pending_req: got seen=%b data=%h need 1/11", seen, d); end
    btn_minus_n = 1'b0;
    ticks(3);
    btn_minus_n = 1'b1;
    ticks(5);
    total++; if (vol_o !== 5'd16) begin bad++; $display("FAIL en_after_reenable: got %0d need 16", vol_o); end
    ack_once(d, seen);
  endtask

  task automatic test_mute();
    logic [5:0] d;
    bit         seen;
    init_dut();
    btn_minus_n = 1'b0;
    btn_plus_n = 1'b0;
    ticks(6);
`ifdef VOL_MUTE_EN
    total++; if (mute_o !== 1'b1 || vol_o !== 5'd16) begin bad++; $display("FAIL mute_toggle: got mute=%b vol=%0d need 1/16", mute_o, vol_o); end
    total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h30) begin bad++; $display("FAIL mute_req: got req=%b data=%h need 1/30", wr_req_o, wr_data_o); end
    btn_minus_n = 1'b1;
    btn_plus_n = 1'b1;
    ticks(5);
    ack_once(d, seen);
    btn_plus_n = 1'b0;
    ticks(3);
    btn_plus_n = 1'b1;
    ticks(2);
    total++; if (mute_o !== 1'b0 || vol_o !== 5'd17) begin bad++; $display("FAIL unmute_step: got mute=%b vol=%0d need 0/17", mute_o, vol_o); end
    total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h11) begin bad++; $display("FAIL unmute_req: got req=%b data=%h need 1/11", wr_req_o, wr_data_o); end
    ack_once(d, seen);
`else
    total++; if (mute_o !== 1'b0 || vol_o !== 5'd16 || wr_req_o !== 1'b0) begin bad++; $display("FAIL both_ignored: got mute=%b vol=%0d req=%b need 0/16/0", mute_o, vol_o, wr_req_o); end
    btn_minus_n = 1'b1;
    btn_plus_n = 1'b1;
    ticks(5);
    total++; if (vol_o !== 5'd16 || wr_req_o !== 1'b0) begin bad++; $display("FAIL both_release: got vol=%0d req=%b need 16/0", vol_o, wr_req_o); end
    ack_once(d, seen);
    total++; if (seen) begin bad++; $display("FAIL both_no_write: got request data=%h need none", d); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [5:0] d;
    bit         seen;
    init_dut();
    btn_plus_n = 1'b0;
    ticks(32);
    total++; if (vol_o !== 5'd19 || wr_req_o !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got vol=%0d req=%b need 19/1", vol_o, wr_req_o); end
    reset = 1'b1;
    #1;
    total++; if (vol_o !== 5'd16 || mute_o !== 1'b0) begin bad++; $display("FAIL rst_mid_async_vol: got vol=%0d mute=%b need 16/0", vol_o, mute_o); end
    total++; if (wr_req_o !== 1'b1 || wr_data_o !== 6'h10) begin bad++; $display("FAIL rst_mid_async_req: got req=%b data=%h need 1/10", wr_req_o, wr_data_o); end
    btn_plus_n = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(2);
    ack_once(d, seen);
    total++; if (!seen || d !== 6'h10) begin bad++; $display("FAIL rst_mid_initial_write: got seen=%b data=%h need 1/10", seen, d); end
    ticks(5);
    total++; if (wr_req_o !== 1'b0 || vol_o !== 5'd16) begin bad++; $display("FAIL rst_mid_abandoned: got req=%b vol=%0d need 0/16", wr_req_o, vol_o); end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_repeat();
    test_saturate();
    test_back_to_back();
    test_enable();
    test_mute();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
